// File: rtl/debounce_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_bank_if                                                         |
// | Button bank bundle: raw levels in, clean levels and strobes out.         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface debounce_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] clean;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] press;

  // master: the board side driving buttons and consuming strobes
  modport master (
    output button,
    input  clean,
    input  rise,
    input  fall,
    input  press
  );

  // slave: the conditioner itself
  modport slave (
    input  button,
    output clean,
    output rise,
    output fall,
    output press
  );
endinterface
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_bank                                                            |
// | Per-channel synchroniser, stable-window debouncer and edge/press strobes.|
// | Optional auto-repeat built when DEBOUNCE_BANK_REPEAT_EN is defined.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 10000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  wire            clk,
  input  wire            rst_n,
  debounce_bank_if.slave bus
);

  localparam int                 c_CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(STABLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_COMMIT = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int                 c_RPT_SPAN   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                               : REPEAT_PERIOD;
  localparam int                 c_RPT_W      = $clog2(c_RPT_SPAN);
  localparam logic [c_RPT_W-1:0] c_RPT_DELAY  = c_RPT_W'(REPEAT_DELAY - 1);
  localparam logic [c_RPT_W-1:0] c_RPT_PERIOD = c_RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [c_RPT_W-1:0] c_RPT_ONE    = c_RPT_W'(1);
`endif

  if (CHANNELS < 1 || STABLE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("debounce_bank: parameter out of range");
  end

  logic [CHANNELS-1:0] w_clean;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_press;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic               r_sync1;
    logic               r_sync2;
    logic               r_st;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_clean;
    logic               r_rise;
    logic               r_fall;
    logic               r_press;
    logic               w_s;
    logic               w_commit;
    logic               w_rise_set;
    logic               w_fall_set;
    logic               w_rep;

    assign w_s        = r_sync2;
    // A bounce on the commit edge fails the s==st test, so it always wins.
    assign w_commit   = (w_s == r_st) && (r_cnt == c_CNT_COMMIT);
    assign w_rise_set = w_commit &&  r_st && !r_clean;
    assign w_fall_set = w_commit && !r_st &&  r_clean;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_st    <= 1'b0;
        r_cnt   <= '0;
        r_clean <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_press <= 1'b0;
      end else begin
        r_sync1 <= bus.button[i];
        r_sync2 <= r_sync1;
        if (w_s != r_st) begin
          r_st  <= w_s;
          r_cnt <= '0;
        end else if (r_cnt < c_CNT_MAX) begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
        if (w_commit) begin
          r_clean <= r_st;
        end
        r_rise  <= w_rise_set;
        r_fall  <= w_fall_set;
        r_press <= w_rise_set | w_rep;
      end
    end

`ifdef DEBOUNCE_BANK_REPEAT_EN
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               r_first;
    logic [c_RPT_W-1:0] w_rpt_last;
    logic               w_rpt_hit;

    assign w_rpt_last = r_first ? c_RPT_DELAY : c_RPT_PERIOD;
    assign w_rpt_hit  = r_clean && (r_rpt_cnt == w_rpt_last);
    // A repeat landing on the release commit edge is dropped.
    assign w_rep      = w_rpt_hit && !w_fall_set;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rpt_cnt <= '0;
        r_first   <= 1'b0;
      end else if (w_rise_set) begin
        r_rpt_cnt <= '0;
        r_first   <= 1'b1;
      end else if (r_clean) begin
        if (w_rpt_hit) begin
          r_rpt_cnt <= '0;
          r_first   <= 1'b0;
        end else begin
          r_rpt_cnt <= r_rpt_cnt + c_RPT_ONE;
        end
      end else begin
        r_rpt_cnt <= '0;
      end
    end
`else
    assign w_rep = 1'b0;
`endif

    assign w_clean[i] = r_clean;
    assign w_rise[i]  = r_rise;
    assign w_fall[i]  = r_fall;
    assign w_press[i] = r_press;
  end

  assign bus.clean = w_clean;
  assign bus.rise  = w_rise;
  assign bus.fall  = w_fall;
  assign bus.press = w_press;

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_debounce_bank                                                         |
// | Directed stimulus with an event scoreboard for rise/fall/press strobes.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_debounce_bank;
  localparam int CH      = 2;
  localparam int STABLE  = 4;
  localparam int RDELAY  = 20;
  localparam int RPERIOD = 8;
  // button driven on a falling edge at cycle n -> strobe seen at cycle n+LAT
  localparam int LAT     = STABLE + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debounce_bank_if #(.CHANNELS(CH)) bus ();

  debounce_bank #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (STABLE),
    .REPEAT_DELAY  (RDELAY),
    .REPEAT_PERIOD (RPERIOD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t   exp_q[$];
  int    cyc      = 0;
  int    checks   = 0;
  int    failures = 0;
  string kname[3] = '{"rise", "fall", "press"};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // rise+press at r, then repeat presses strictly before the fall edge f
  task automatic expect_press(input int r, input int ch, input int f);
    expect_ev(r, ch, 0);
    expect_ev(r, ch, 2);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    for (int t = r + RDELAY; t < f; t += RPERIOD) expect_ev(t, ch, 2);
`else
    if (f < 0) expect_ev(r, ch, 2);
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every asserted strobe must match one queued expectation.
  always @(negedge clk) begin
    logic v;
    bit   found;
    if (rst_n) begin
      for (int ch = 0; ch < CH; ch++) begin
        for (int k = 0; k < 3; k++) begin
          v = (k == 0) ? bus.rise[ch] : (k == 1) ? bus.fall[ch] : bus.press[ch];
          if (v !== 1'b0) begin
            found = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (!found && exp_q[i].cyc == cyc && exp_q[i].ch == ch && exp_q[i].kind == k) begin
                exp_q.delete(i);
                found = 1'b1;
              end
            end
            checks++;
            if (!found) begin
              failures++;
              $display("FAIL strobe_%s ch=%0d: got %b at cycle %0d, expected none",
                       kname[k], ch, v, cyc);
            end
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_clean"}, 32'(bus.clean), 32'd0);
    check({tag, "_rise"},  32'(bus.rise),  32'd0);
    check({tag, "_fall"},  32'(bus.fall),  32'd0);
    check({tag, "_press"}, 32'(bus.press), 32'd0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t0;
    int r;
    int m;
    bus.button = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clean press on channel 0, held 30 cycles
    t0 = cyc;
    bus.button[0] = 1'b1;
    expect_press(t0 + LAT, 0, t0 + 30 + LAT);
    wait_until(t0 + 10);
    check("press_clean", 32'(bus.clean), 32'h1);
    wait_until(t0 + 30);
    bus.button[0] = 1'b0;
    expect_ev(t0 + 30 + LAT, 0, 1);
    repeat (15) @(negedge clk);
    check("release_clean", 32'(bus.clean), 32'h0);

    // bounce then long hold; release so the fall lands on the +60 repeat slot
    t0 = cyc;
    bus.button[0] = 1'b1; repeat (2) @(negedge clk);
    bus.button[0] = 1'b0; repeat (2) @(negedge clk);
    bus.button[0] = 1'b1; repeat (2) @(negedge clk);
    bus.button[0] = 1'b0; repeat (2) @(negedge clk);
    bus.button[0] = 1'b1;
    r = t0 + 8 + LAT;
    expect_press(r, 0, r + 60);
    expect_ev(r + 60, 0, 1);
    wait_until(r + 3);
    check("bounce_clean", 32'(bus.clean), 32'h1);
    wait_until(r + 53);
    bus.button[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("bounce_release_clean", 32'(bus.clean), 32'h0);

    // short glitch on channel 1
    bus.button[1] = 1'b1; repeat (3) @(negedge clk);
    bus.button[1] = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_clean", 32'(bus.clean), 32'h0);

    // async reset mid-hold
    t0 = cyc;
    bus.button[0] = 1'b1;
    expect_press(t0 + LAT, 0, t0 + LAT + 6);
    wait_until(t0 + LAT + 5);
    check("pre_reset_clean", 32'(bus.clean), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m = cyc;
    expect_press(m + LAT, 0, m + 10 + LAT);
    wait_until(m + 10);
    check("post_reset_clean", 32'(bus.clean), 32'h1);
    bus.button[0] = 1'b0;
    expect_ev(m + 10 + LAT, 0, 1);
    repeat (15) @(negedge clk);
    check("post_reset_release", 32'(bus.clean), 32'h0);

    // simultaneous press on both channels
    t0 = cyc;
    bus.button = 2'b11;
    expect_press(t0 + LAT, 0, t0 + 10 + LAT);
    expect_press(t0 + LAT, 1, t0 + 10 + LAT);
    wait_until(t0 + 10);
    check("simul_clean", 32'(bus.clean), 32'h3);
    bus.button = 2'b00;
    expect_ev(t0 + 10 + LAT, 0, 1);
    expect_ev(t0 + 10 + LAT, 1, 1);
    repeat (15) @(negedge clk);
    check("simul_release", 32'(bus.clean), 32'h0);

    // every queued strobe must have been observed
    foreach (exp_q[i]) begin
      checks++;
      failures++;
      $display("FAIL missing_%s ch=%0d: got none, expected strobe at cycle %0d",
               kname[exp_q[i].kind], exp_q[i].ch, exp_q[i].cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
